vec_addsub_pipe: RTL

Parametrised, pipelined SIMD integer add/subtract unit for the vector execution lane. It splits a DATA_W-bit operand pair into 8/16/32-bit elements and applies the selected operation per element: wrapping add, subtract, reverse-subtract, and signed or unsigned saturating add/subtract. Each element has a mask bit, and masked-off elements keep the old destination value. The unit has two register stages with valid/ready handshakes on both sides, and feeds the lane writeback mux in place of the older combinational 32-bit adder/subtractor.

---
 rtl/vec_addsub_pipe_if.sv | 37 +++
 rtl/vec_addsub_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_addsub_pipe_if.sv
// Request/response bundle for the SIMD add/subtract unit.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. While valid is high and ready is low the
// producer holds valid and its payload stable. A ready never depends on
// the valid of the same side.
interface vec_addsub_pipe_if #(
    parameter int DATA_W = 128
) ();
    localparam int NBYTE = DATA_W / 8;

    // request side
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [1:0]        sew;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] vd_old;
    logic [NBYTE-1:0]  mask;

    // response side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              sat;

    modport slave (
        input  in_valid, op, sew, a, b, vd_old, mask, out_ready,
        output in_ready, out_valid, result, sat
    );

    modport master (
        output in_valid, op, sew, a, b, vd_old, mask, out_ready,
        input  in_ready, out_valid, result, sat
    );
endinterface

// File: rtl/vec_addsub_pipe.sv
// Two-stage SIMD integer add/subtract unit. Stage 1 runs a segmented
// byte carry chain (segments follow the element width); stage 2 applies
// per-element saturation and merges masked-off elements from vd_old.
module vec_addsub_pipe #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    vec_addsub_pipe_if.slave  bus
);
    localparam int NBYTE = DATA_W / 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RSUB  = 3'b010;
    localparam logic [2:0] OP_SADDU = 3'b011;
    localparam logic [2:0] OP_SADD  = 3'b100;
    localparam logic [2:0] OP_SSUBU = 3'b101;
    localparam logic [2:0] OP_SSUB  = 3'b110;

    // ---------------- handshake control ----------------
    logic s1_valid;
    logic out_valid_q;
    logic s2_en;
    logic s1_en;

    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // ---------------- stage 0: operand prep + carry chain ----------------
    logic              sub_form;
    logic              rsub_form;
    logic              cin_op;
    logic [1:0]        sew_eff;
    logic [DATA_W-1:0] opx;
    logic [DATA_W-1:0] opy;

    // Select effective operands; subtract forms invert one side and inject carry 1.
    always_comb begin
        sub_form  = (bus.op == OP_SUB) || (bus.op == OP_SSUBU) || (bus.op == OP_SSUB);
        rsub_form = (bus.op == OP_RSUB);
        cin_op    = sub_form || rsub_form;
        sew_eff   = (bus.sew == 2'b11) ? 2'b10 : bus.sew;
        opx       = rsub_form ? bus.b : bus.a;
        opy       = rsub_form ? ~bus.a : (sub_form ? ~bus.b : bus.b);
    end

    logic [DATA_W-1:0] sum;
    logic [NBYTE-1:0]  carry_out;
    logic [NBYTE-1:0]  sign_x;
    logic [NBYTE-1:0]  sign_y;
    logic [NBYTE-1:0]  sign_s;
    logic              chain_c;
    logic              boundary;

    // Byte-wise ripple chain, restarting with the op carry at element boundaries.
    always_comb begin
        sum       = '0;
        carry_out = '0;
        sign_x    = '0;
        sign_y    = '0;
        sign_s    = '0;
        chain_c   = cin_op;
        boundary  = 1'b1;
        for (int k = 0; k < NBYTE; k++) begin
            case (sew_eff)
                2'b00:   boundary = 1'b1;
                2'b01:   boundary = (k % 2 == 0);
                default: boundary = (k % 4 == 0);
            endcase
            if (boundary) begin
                chain_c = cin_op;
            end
            {carry_out[k], sum[8*k +: 8]} = {1'b0, opx[8*k +: 8]} + {1'b0, opy[8*k +: 8]}
                                          + {8'b0, chain_c};
            chain_c   = carry_out[k];
            sign_x[k] = opx[8*k + 7];
            sign_y[k] = opy[8*k + 7];
            sign_s[k] = sum[8*k + 7];
        end
    end

    // ---------------- stage 1 registers ----------------
    // Carry and sign bits are kept per byte; stage 2 only reads the
    // element's top byte, the others are don't-care.
    logic [DATA_W-1:0] s1_sum;
    logic [NBYTE-1:0]  s1_cout;
    logic [NBYTE-1:0]  s1_xs;
    logic [NBYTE-1:0]  s1_ys;
    logic [NBYTE-1:0]  s1_ss;
    logic [2:0]        s1_op;
    logic [1:0]        s1_sew;
    logic [NBYTE-1:0]  s1_mask;
    logic [DATA_W-1:0] s1_vd_old;

    // Stage 1 capture: loads on accept, empties when drained without refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_cout   <= '0;
            s1_xs     <= '0;
            s1_ys     <= '0;
            s1_ss     <= '0;
            s1_op     <= '0;
            s1_sew    <= '0;
            s1_mask   <= '0;
            s1_vd_old <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum    <= sum;
                s1_cout   <= carry_out;
                s1_xs     <= sign_x;
                s1_ys     <= sign_y;
                s1_ss     <= sign_s;
                s1_op     <= bus.op;
                s1_sew    <= sew_eff;
                s1_mask   <= bus.mask;
                s1_vd_old <= bus.vd_old;
            end
        end
    end

    // ---------------- stage 2: saturation + mask merge ----------------
    logic [DATA_W-1:0] s2_result;
    logic              s2_sat;
    logic              t_cout;
    logic              t_xs;
    logic              t_ys;
    logic              t_ss;
    logic              is_top;
    logic              active;
    logic              elem_sat;
    logic [7:0]        sat_byte;

    // Per byte: look up the owning element's top-byte flags and mask bit, then pick the byte.
    always_comb begin
        s2_result = '0;
        s2_sat    = 1'b0;
        t_cout    = 1'b0;
        t_xs      = 1'b0;
        t_ys      = 1'b0;
        t_ss      = 1'b0;
        is_top    = 1'b0;
        active    = 1'b0;
        elem_sat  = 1'b0;
        sat_byte  = '0;
        for (int k = 0; k < NBYTE; k++) begin
            case (s1_sew)
                2'b00: begin
                    t_cout = s1_cout[k];
                    t_xs   = s1_xs[k];
                    t_ys   = s1_ys[k];
                    t_ss   = s1_ss[k];
                    is_top = 1'b1;
                    active = s1_mask[k];
                end
                2'b01: begin
                    t_cout = s1_cout[k | 1];
                    t_xs   = s1_xs[k | 1];
                    t_ys   = s1_ys[k | 1];
                    t_ss   = s1_ss[k | 1];
                    is_top = (k % 2 == 1);
                    active = s1_mask[k / 2];
                end
                default: begin
                    t_cout = s1_cout[k | 3];
                    t_xs   = s1_xs[k | 3];
                    t_ys   = s1_ys[k | 3];
                    t_ss   = s1_ss[k | 3];
                    is_top = (k % 4 == 3);
                    active = s1_mask[k / 4];
                end
            endcase

            elem_sat = 1'b0;
            sat_byte = s1_sum[8*k +: 8];
            case (s1_op)
                OP_SADDU: begin
                    elem_sat = t_cout;
                    sat_byte = 8'hFF;
                end
                OP_SSUBU: begin
                    elem_sat = !t_cout;
                    sat_byte = 8'h00;
                end
                OP_SADD, OP_SSUB: begin
                    elem_sat = (t_xs == t_ys) && (t_ss != t_xs);
                    if (t_xs) sat_byte = is_top ? 8'h80 : 8'h00;
                    else      sat_byte = is_top ? 8'h7F : 8'hFF;
                end
                default: ;
            endcase

            if (!active)       s2_result[8*k +: 8] = s1_vd_old[8*k +: 8];
            else if (elem_sat) s2_result[8*k +: 8] = sat_byte;
            else               s2_result[8*k +: 8] = s1_sum[8*k +: 8];
            s2_sat = s2_sat | (active & elem_sat);
        end
    end

    logic [DATA_W-1:0] result_q;
    logic              sat_q;

    // Output register: advances when empty or consumed, holds during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= s2_result;
                sat_q    <= s2_sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.sat       = sat_q;

    // OP_ADD is the fall-through arm of the op decode above.
    localparam logic [2:0] OP_DEFAULT_ARM = OP_ADD;
endmodule
